// File: rtl/serial_parity_rx.sv
// serial_parity_rx: receives one serial frame at a time and checks it.
//   Frame: start(0), DATA_BITS data bits LSB-first, parity bit, stop(1).
//   Only edges with bit_valid=1 advance the receiver.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   bit_valid  - qualifies bit_in
//   bit_in     - serial line value
//   data_out   - data bits of the last completed frame
//   data_valid - one-cycle pulse after a frame's stop bit is accepted
//   parity_err - parity mismatch in the last completed frame
//   frame_err  - stop bit was 0 in the last completed frame
//   busy       - receiver is inside a frame (state != IDLE)
module serial_parity_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int            CW   = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shadow;
  logic [CW-1:0]        cnt;
  logic                 par;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bit_valid) begin
      case (state)
        IDLE:    if (!bit_in) state_nxt = DATA;
        DATA:    if (cnt == LAST) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Data bits enter at the MSB and walk down, so after DATA_BITS shifts the
  // first received bit sits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: if (!bit_in) begin
            shadow <= '0;
            cnt    <= '0;
            par    <= 1'b0;
          end
          DATA: begin
            shadow <= {bit_in, shadow[DATA_BITS-1:1]};
            par    <= par ^ bit_in;
            cnt    <= cnt + CW'(1);
          end
          PARITY: par <= par ^ bit_in;
          STOP: begin
            // A bad stop bit still completes the frame; it is only flagged.
            data_out   <= shadow;
            parity_err <= par ^ ODD_PARITY;
            frame_err  <= ~bit_in;
            data_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: an even-parity and an odd-parity instance share
// the same serial stimulus; expected results come from a table of known
// frames and from a popcount-based model for random frames.
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       rst, bit_valid, bit_in;
  logic [7:0] dout_e, dout_o;
  logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  int checks = 0, passed = 0;
  int pulses = 0;
  logic [7:0] cap_q[$];
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e),
    .frame_err(fe_e), .busy(busy_e));

  serial_parity_rx #(.DATA_BITS(8), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o),
    .frame_err(fe_o), .busy(busy_o));

  // Outputs only move on posedge, so sampling on negedge is race-free.
  always @(negedge clk) if (dv_e) begin
    pulses++;
    cap_q.push_back(dout_e);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic send_bit(input logic b, input int gmin, input int gmax);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    repeat ($urandom_range(gmax, gmin)) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);  // ignored while bit_valid is low
    end
  endtask

  // Sends a full frame. Unless b2b, checks the completion cycle and that the
  // pulse lasts exactly one cycle. Before the stop bit, checks the previous
  // result is still held and the receiver reports busy.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int gmin, input int gmax, input bit b2b,
                            input logic xpe_e, input logic xpe_o, input logic xfe);
    send_bit(1'b0, gmin, gmax);
    for (int i = 0; i < 8; i++) send_bit(d[i], gmin, gmax);
    send_bit(p, gmin, gmax);
    @(negedge clk);
    chk("busy_in_frame", busy_e, 1'b1);
    chk("hold_data_out", dout_e, prev_data);
    bit_valid = 1'b1;
    bit_in    = s;
    if (!b2b) begin
      @(negedge clk);
      bit_valid = 1'b0;
      chk("dv_even", dv_e, 1'b1);
      chk("dv_odd", dv_o, 1'b1);
      chk("data_even", dout_e, d);
      chk("data_odd", dout_o, d);
      chk("perr_even", pe_e, xpe_e);
      chk("perr_odd", pe_o, xpe_o);
      chk("ferr_even", fe_e, xfe);
      chk("ferr_odd", fe_o, xfe);
      chk("busy_after", busy_e, 1'b0);
      @(negedge clk);
      chk("dv_one_cycle", dv_e, 1'b0);
    end
    prev_data = d;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p, s;
    int         gmin, gmax;
    logic       xpe_e, xpe_o, xfe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int p0;
    logic [7:0] d;
    logic pb, sb;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 1, 3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    prev_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_e, 1'b0);
    chk("rst_dv", dv_e, 1'b0);
    chk("rst_data", dout_e, 8'h00);
    chk("rst_perr", pe_e, 1'b0);
    chk("rst_ferr", fe_e, 1'b0);
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].gmin, vecs[i].gmax,
                 1'b0, vecs[i].xpe_e, vecs[i].xpe_o, vecs[i].xfe);

    // Back-to-back: second start bit on the edge right after the first stop.
    cap_q.delete();
    p0 = pulses;
    send_frame(8'h01, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_first", (cap_q.size() > 0) ? cap_q[0] : 8'hxx, 8'h01);
    chk("b2b_second", (cap_q.size() > 1) ? cap_q[1] : 8'hxx, 8'hFE);

    // Reset after 4 data bits discards the partial frame.
    p0 = pulses;
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 0);
    @(negedge clk);
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_data", dout_o, 8'h00);
    chk("midrst_dv", dv_o, 1'b0);
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b1;
    prev_data = 8'h00;
    send_frame(8'h55, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("midrst_pulses", pulses - p0, 1);

    // Random frames against the parity rule: error when the number of ones
    // over data plus parity bit disagrees with the selected sense.
    p0 = pulses;
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(3, 0) != 0);
      repeat ($urandom_range(2, 0)) send_bit(1'b1, 0, 1);
      send_frame(d, pb, sb, 0, 2, 1'b0,
                 (($countones(d) + pb) % 2) != 0,
                 (($countones(d) + pb) % 2) != 1,
                 ~sb);
    end
    chk("rand_pulses", pulses - p0, 40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
